// File: rtl/controle_multiciclo_if.sv
`default_nettype none
// ============================================================================
//  Module      : controle_multiciclo_if
//  Description : Bundle between the multicycle controller and its
//                surroundings: instruction memory, the ALU zero flag, the
//                PC update block (somapc) and the datapath enables.
//                  master : controller view (drives state and strobes)
//                  slave  : datapath / memory / somapc view
//  Signals     : instrucao, zero                  -> controller
//                estado, pcsrc, immediate, negativo -> somapc
//                ir_we, reg_we, mem_re, mem_we,
//                alu_src, alu_op, mem_to_reg       -> datapath
//                halted, erro, instr_count         -> status
//  Revision    : 1.0 - initial release
// ============================================================================
interface controle_multiciclo_if #(
    parameter int W_CNT = 32
);
    logic [31:0]      instrucao;
    logic             zero;
    logic [3:0]       estado;
    logic             pcsrc;
    logic [31:0]      immediate;
    logic             negativo;
    logic             ir_we;
    logic             reg_we;
    logic             mem_re;
    logic             mem_we;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             mem_to_reg;
    logic             halted;
    logic             erro;
    logic [W_CNT-1:0] instr_count;

    modport master (
        input  instrucao, zero,
        output estado, pcsrc, immediate, negativo,
        output ir_we, reg_we, mem_re, mem_we, alu_src, alu_op, mem_to_reg,
        output halted, erro, instr_count
    );

    modport slave (
        output instrucao, zero,
        input  estado, pcsrc, immediate, negativo,
        input  ir_we, reg_we, mem_re, mem_we, alu_src, alu_op, mem_to_reg,
        input  halted, erro, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/controle_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : controle_multiciclo
//  Description : Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/PCUPD/HALT)
//                for a small RV32I subset. Latches the instruction, decodes
//                it, drives datapath strobes and presents the branch decision
//                and offset magnitude/sign to somapc during PCUPD.
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous, active-high
//                bus   - controle_multiciclo_if.master (see interface file)
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_multiciclo #(
    parameter int W_CNT = 32
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    controle_multiciclo_if.master     bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'b0001,
        S_DECODE = 4'b0010,
        S_EXEC   = 4'b0100,
        S_MEM    = 4'b0110,
        S_WB     = 4'b0111,
        S_PCUPD  = 4'b1000,
        S_HALT   = 4'b1111
    } state_t;

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_ADDI  = 7'b0010011;
    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_ECALL = 7'b1110011;

    localparam logic [W_CNT-1:0] c_CNT_ONE = {{(W_CNT-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_ir;
    logic             r_pcsrc;
    logic [31:0]      r_immediate;
    logic             r_negativo;
    logic             r_halted;
    logic             r_erro;
    logic [W_CNT-1:0] r_instr_count;

    // Instruction field decode
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7_5;
    logic        w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_br, w_is_ecall;
    logic        w_is_known;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_mag;
    logic        w_taken;

    // Register-source fields are consumed by the datapath, not here.
    logic        w_unused_ir;

    assign w_opcode   = r_ir[6:0];
    assign w_funct3   = r_ir[14:12];
    assign w_funct7_5 = r_ir[30];
    assign w_unused_ir = ^r_ir[24:15];

    assign w_is_r     = (w_opcode == c_OP_R);
    assign w_is_addi  = (w_opcode == c_OP_ADDI);
    assign w_is_lw    = (w_opcode == c_OP_LW);
    assign w_is_sw    = (w_opcode == c_OP_SW);
    assign w_is_br    = (w_opcode == c_OP_BR);
    assign w_is_ecall = (w_opcode == c_OP_ECALL);
    assign w_is_known = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_br;

    // B-type immediate, sign-extended; somapc wants magnitude + sign.
    assign w_imm_b   = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_mag = w_imm_b[31] ? (~w_imm_b + 32'd1) : w_imm_b;

    always_comb begin
        w_taken = 1'b0;
        if (w_funct3 == 3'b000) begin
            w_taken = bus.zero;
        end else if (w_funct3 == 3'b001) begin
            w_taken = ~bus.zero;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes (decoded from current state and IR)
    // ------------------------------------------------------------------
    logic       w_ir_we, w_reg_we, w_mem_re, w_mem_we;
    logic       w_alu_src, w_mem_to_reg;
    logic [1:0] w_alu_op;

    always_comb begin
        w_next_state = r_state;
        w_ir_we      = 1'b0;
        w_reg_we     = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = 2'b00;
        w_mem_to_reg = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_ir_we      = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_known) begin
                    w_next_state = S_EXEC;
                end else if (w_is_ecall) begin
                    w_next_state = S_HALT;
                end else begin
                    // Unknown opcode: skip the instruction, PC+1
                    w_next_state = S_PCUPD;
                end
            end
            S_EXEC: begin
                w_alu_src = w_is_addi | w_is_lw | w_is_sw;
                if (w_is_r) begin
                    case (w_funct3)
                        3'b000:  w_alu_op = {1'b0, w_funct7_5};
                        3'b111:  w_alu_op = 2'b10;
                        3'b110:  w_alu_op = 2'b11;
                        default: w_alu_op = 2'b00;
                    endcase
                end else if (w_is_br) begin
                    w_alu_op = 2'b01;
                end
                if (w_is_lw || w_is_sw) begin
                    w_next_state = S_MEM;
                end else if (w_is_br) begin
                    w_next_state = S_PCUPD;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                w_mem_re     = w_is_lw;
                w_mem_we     = w_is_sw;
                w_next_state = w_is_lw ? S_WB : S_PCUPD;
            end
            S_WB: begin
                w_reg_we     = 1'b1;
                w_mem_to_reg = w_is_lw;
                w_next_state = S_PCUPD;
            end
            S_PCUPD: begin
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered PC-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_ir          <= 32'd0;
            r_pcsrc       <= 1'b0;
            r_immediate   <= 32'd0;
            r_negativo    <= 1'b0;
            r_halted      <= 1'b0;
            r_erro        <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;

            if (r_state == S_FETCH) begin
                r_ir <= bus.instrucao;
            end

            if (r_state == S_DECODE) begin
                if (w_is_ecall) begin
                    r_halted <= 1'b1;
                end else if (!w_is_known) begin
                    r_erro <= 1'b1;
                end
            end

            if (r_state == S_EXEC) begin
                // A not-taken branch presents a clean zero offset so
                // somapc sees PC+1 with no stale magnitude.
                if (w_is_br && w_taken) begin
                    r_pcsrc     <= 1'b1;
                    r_negativo  <= w_imm_b[31];
                    r_immediate <= w_imm_mag;
                end else begin
                    r_pcsrc     <= 1'b0;
                    r_negativo  <= 1'b0;
                    r_immediate <= 32'd0;
                end
            end

            if (r_state == S_PCUPD) begin
                r_pcsrc       <= 1'b0;
                r_negativo    <= 1'b0;
                r_immediate   <= 32'd0;
                r_instr_count <= r_instr_count + c_CNT_ONE;
            end
        end
    end

    // Strobes are forced low while reset is asserted so nothing is written
    // during the restart cycle.
    assign bus.ir_we       = w_ir_we      & ~reset;
    assign bus.reg_we      = w_reg_we     & ~reset;
    assign bus.mem_re      = w_mem_re     & ~reset;
    assign bus.mem_we      = w_mem_we     & ~reset;
    assign bus.alu_src     = w_alu_src    & ~reset;
    assign bus.alu_op      = w_alu_op     & {2{~reset}};
    assign bus.mem_to_reg  = w_mem_to_reg & ~reset;

    assign bus.estado      = r_state;
    assign bus.pcsrc       = r_pcsrc;
    assign bus.immediate   = r_immediate;
    assign bus.negativo    = r_negativo;
    assign bus.halted      = r_halted;
    assign bus.erro        = r_erro;
    assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_controle_multiciclo
//  Description : Directed self-checking bench for controle_multiciclo.
//                Walks addi, lw, sw, beq/bne, R-type, unknown opcode, a
//                mid-instruction reset and ecall, comparing state, strobes
//                and PC-side outputs against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_multiciclo;

    localparam logic [3:0] ST_FETCH  = 4'b0001;
    localparam logic [3:0] ST_DECODE = 4'b0010;
    localparam logic [3:0] ST_EXEC   = 4'b0100;
    localparam logic [3:0] ST_MEM    = 4'b0110;
    localparam logic [3:0] ST_WB     = 4'b0111;
    localparam logic [3:0] ST_PCUPD  = 4'b1000;
    localparam logic [3:0] ST_HALT   = 4'b1111;

    // strobe vector order: {ir_we, reg_we, mem_re, mem_we}
    localparam logic [3:0] SB_NONE = 4'b0000;
    localparam logic [3:0] SB_IR   = 4'b1000;
    localparam logic [3:0] SB_REG  = 4'b0100;
    localparam logic [3:0] SB_RD   = 4'b0010;
    localparam logic [3:0] SB_WR   = 4'b0001;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    controle_multiciclo_if #(.W_CNT(32)) bus ();

    controle_multiciclo #(.W_CNT(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp_v);
        chk(tag, 32'(obs), 32'(exp_v));
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp_v);
        chk(tag, 32'(bus.estado), 32'(exp_v));
    endtask

    task automatic chk_stb(input string tag, input logic [3:0] exp_v);
        chk(tag, 32'({bus.ir_we, bus.reg_we, bus.mem_re, bus.mem_we}), 32'(exp_v));
    endtask

    // Full R-type pass from FETCH back to FETCH, checking alu_op in EXEC.
    task automatic run_r(input string tag, input logic [31:0] instr, input logic [1:0] op);
        bus.instrucao = instr;
        tick();
        chk_st({tag, "_decode"}, ST_DECODE);
        tick();
        chk_st({tag, "_exec"}, ST_EXEC);
        chk(  {tag, "_alu_op"}, 32'(bus.alu_op), 32'(op));
        chk_b({tag, "_alu_src"}, bus.alu_src, 1'b0);
        tick();
        chk_stb({tag, "_wb"}, SB_REG);
        tick();
        chk_st({tag, "_pcupd"}, ST_PCUPD);
        tick();
        chk_st({tag, "_fetch"}, ST_FETCH);
    endtask

    initial begin
        reset         = 1'b1;
        bus.instrucao = 32'd0;
        bus.zero      = 1'b0;
        tick();
        tick();

        // Reset state
        chk_st ("rst_estado", ST_FETCH);
        chk_stb("rst_strobes", SB_NONE);
        chk    ("rst_count", bus.instr_count, 32'd0);
        chk_b  ("rst_pcsrc", bus.pcsrc, 1'b0);
        chk_b  ("rst_halted", bus.halted, 1'b0);
        chk_b  ("rst_erro", bus.erro, 1'b0);

        // addi x1,x0,5
        bus.instrucao = 32'h00500093;
        reset = 1'b0;
        #1;
        chk_stb("addi_fetch", SB_IR);
        tick();
        chk_st ("addi_decode", ST_DECODE);
        chk_stb("addi_decode_stb", SB_NONE);
        tick();
        chk_st ("addi_exec", ST_EXEC);
        chk_b  ("addi_alu_src", bus.alu_src, 1'b1);
        chk    ("addi_alu_op", 32'(bus.alu_op), 32'd0);
        chk_stb("addi_exec_stb", SB_NONE);
        tick();
        chk_st ("addi_wb", ST_WB);
        chk_stb("addi_wb_stb", SB_REG);
        chk_b  ("addi_m2r", bus.mem_to_reg, 1'b0);
        tick();
        chk_st ("addi_pcupd", ST_PCUPD);
        chk_b  ("addi_pcsrc", bus.pcsrc, 1'b0);
        tick();
        chk_st ("addi_fetch2", ST_FETCH);
        chk    ("addi_count", bus.instr_count, 32'd1);

        // lw x2,0(x1)
        bus.instrucao = 32'h0000A103;
        tick();
        tick();
        chk_b  ("lw_alu_src", bus.alu_src, 1'b1);
        tick();
        chk_st ("lw_mem", ST_MEM);
        chk_stb("lw_mem_stb", SB_RD);
        tick();
        chk_st ("lw_wb", ST_WB);
        chk_stb("lw_wb_stb", SB_REG);
        chk_b  ("lw_m2r", bus.mem_to_reg, 1'b1);
        tick();
        chk_st ("lw_pcupd", ST_PCUPD);
        tick();
        chk    ("lw_count", bus.instr_count, 32'd2);

        // sw x2,0(x1)
        bus.instrucao = 32'h0020A023;
        tick();
        tick();
        tick();
        chk_st ("sw_mem", ST_MEM);
        chk_stb("sw_mem_stb", SB_WR);
        tick();
        chk_st ("sw_pcupd", ST_PCUPD);
        tick();
        chk    ("sw_count", bus.instr_count, 32'd3);

        // beq offset -4, taken
        bus.instrucao = 32'hFE000EE3;
        bus.zero      = 1'b1;
        tick();
        tick();
        chk    ("beq_alu_op", 32'(bus.alu_op), 32'd1);
        tick();
        chk_st ("beq_pcupd", ST_PCUPD);
        chk_b  ("beq_pcsrc", bus.pcsrc, 1'b1);
        chk_b  ("beq_neg", bus.negativo, 1'b1);
        chk    ("beq_imm", bus.immediate, 32'd4);
        tick();
        chk_b  ("beq_pcsrc_clr", bus.pcsrc, 1'b0);
        chk    ("beq_imm_clr", bus.immediate, 32'd0);
        chk_b  ("beq_neg_clr", bus.negativo, 1'b0);
        chk    ("beq_count", bus.instr_count, 32'd4);

        // beq offset -4, not taken
        bus.zero = 1'b0;
        tick();
        tick();
        tick();
        chk_st ("beqn_pcupd", ST_PCUPD);
        chk_b  ("beqn_pcsrc", bus.pcsrc, 1'b0);
        chk    ("beqn_imm", bus.immediate, 32'd0);
        tick();
        chk    ("beqn_count", bus.instr_count, 32'd5);

        // bne offset +8, taken
        bus.instrucao = 32'h00001463;
        bus.zero      = 1'b0;
        tick();
        tick();
        tick();
        chk_b  ("bne_pcsrc", bus.pcsrc, 1'b1);
        chk_b  ("bne_neg", bus.negativo, 1'b0);
        chk    ("bne_imm", bus.immediate, 32'd8);
        tick();

        // beq offset 0, taken
        bus.instrucao = 32'h00000063;
        bus.zero      = 1'b1;
        tick();
        tick();
        tick();
        chk_b  ("beq0_pcsrc", bus.pcsrc, 1'b1);
        chk    ("beq0_imm", bus.immediate, 32'd0);
        tick();
        bus.zero = 1'b0;

        // R-type ALU ops
        run_r("add", 32'h002081B3, 2'b00);
        run_r("sub", 32'h402081B3, 2'b01);
        run_r("and", 32'h0020F1B3, 2'b10);
        run_r("or",  32'h0020E1B3, 2'b11);
        chk    ("r_count", bus.instr_count, 32'd11);

        // Unknown opcode: DECODE -> PCUPD
        bus.instrucao = 32'h0000007F;
        tick();
        chk_b  ("unk_erro_pre", bus.erro, 1'b0);
        tick();
        chk_st ("unk_pcupd", ST_PCUPD);
        chk_b  ("unk_erro", bus.erro, 1'b1);
        chk_b  ("unk_pcsrc", bus.pcsrc, 1'b0);
        tick();
        chk    ("unk_count", bus.instr_count, 32'd12);

        // Reset during MEM of a lw
        bus.instrucao = 32'h0000A103;
        tick();
        tick();
        tick();
        chk_st ("rlw_mem", ST_MEM);
        reset = 1'b1;
        tick();
        chk_st ("rlw_estado", ST_FETCH);
        chk_stb("rlw_strobes", SB_NONE);
        chk    ("rlw_count", bus.instr_count, 32'd0);
        chk_b  ("rlw_erro", bus.erro, 1'b0);

        // Next instruction after reset runs normally
        bus.instrucao = 32'h00500093;
        reset = 1'b0;
        #1;
        chk_stb("post_fetch", SB_IR);
        tick();
        tick();
        tick();
        chk_st ("post_wb", ST_WB);
        tick();
        chk_st ("post_pcupd", ST_PCUPD);
        tick();
        chk    ("post_count", bus.instr_count, 32'd1);

        // ecall -> HALT, absorbing
        bus.instrucao = 32'h00000073;
        tick();
        tick();
        chk_st ("ecall_halt", ST_HALT);
        chk_b  ("ecall_halted", bus.halted, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_st("halt_hold", ST_HALT);
        end
        chk_stb("halt_strobes", SB_NONE);
        chk    ("halt_count", bus.instr_count, 32'd1);

        // Reset leaves HALT
        reset = 1'b1;
        tick();
        chk_st ("unhalt_estado", ST_FETCH);
        chk_b  ("unhalt_halted", bus.halted, 1'b0);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
